// File: rtl/demux_stream.sv
// Valid/ready stream demultiplexer: routes each accepted word to one of NUM_CH
// single-entry output registers, with per-channel saturating delivery counters.
module demux_stream #(
    parameter int DATA_W    = 4,
    parameter int NUM_CH    = 4,
    parameter int SEL_W     = 2,
    parameter int HOLD_MODE = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [SEL_W-1:0]         in_sel,
    output logic [NUM_CH-1:0]        out_valid,
    input  logic [NUM_CH-1:0]        out_ready,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic                     sel_err,
    input  logic                     cnt_clr,
    output logic [NUM_CH*8-1:0]      xfer_cnt
);

    logic [NUM_CH-1:0] hit;
    logic [NUM_CH-1:0] pop;
    logic              sel_ok;
    logic              accept;

    logic [DATA_W-1:0] data_q [NUM_CH];
    logic [7:0]        cnt_q  [NUM_CH];

    // NOTE: combinational logic uses blocking '=' with every output given a
    // default first, so no path can fall through and infer a latch.
    // An out-of-range select matches no channel and is always ready (dropped).
    always_comb begin
        hit      = '0;
        in_ready = 1'b1;
        for (int k = 0; k < NUM_CH; k++) begin
            if (in_sel == SEL_W'(k)) begin
                hit[k]   = 1'b1;
                in_ready = ~out_valid[k] | out_ready[k];
            end
        end
    end

    assign sel_ok = |hit;
    assign accept = in_valid & in_ready;
    assign pop    = out_valid & out_ready;

    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // pre-edge values. The data registers are reset too, because out_data
    // must read zero while rst_n is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= '0;
            sel_err   <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                data_q[k] <= '0;
                cnt_q[k]  <= '0;
            end
        end else begin
            sel_err <= accept & ~sel_ok;
            for (int k = 0; k < NUM_CH; k++) begin
                // A load wins over a pop, giving back-to-back flow with no bubble.
                if (accept && hit[k]) begin
                    out_valid[k] <= 1'b1;
                    data_q[k]    <= in_data;
                end else if (pop[k]) begin
                    out_valid[k] <= 1'b0;
                    if (HOLD_MODE == 0) data_q[k] <= '0;
                end

                if (cnt_clr)
                    cnt_q[k] <= '0;
                else if (pop[k] && cnt_q[k] != 8'hFF)
                    cnt_q[k] <= cnt_q[k] + 8'd1;
            end
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_flat
        assign out_data[k*DATA_W +: DATA_W] = data_q[k];
        assign xfer_cnt[k*8 +: 8]           = cnt_q[k];
    end

endmodule

// File: tb/tb_demux_stream.sv
// Randomized scoreboard bench for demux_stream (4-channel hold instance) plus
// directed checks on a 3-channel zeroing instance for out-of-range selects.
module tb_demux_stream;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Main instance: DATA_W=4, NUM_CH=4, HOLD_MODE=1
    logic        in_valid = 1'b0, in_ready, sel_err, cnt_clr = 1'b0;
    logic [3:0]  in_data = '0;
    logic [1:0]  in_sel = '0;
    logic [3:0]  out_valid, out_ready = '0;
    logic [15:0] out_data;
    logic [31:0] xfer_cnt;

    // Second instance: NUM_CH=3, SEL_W=2, HOLD_MODE=0
    logic        v3 = 1'b0, r3, se3, clr3 = 1'b0;
    logic [3:0]  d3 = '0;
    logic [1:0]  s3 = '0;
    logic [2:0]  ov3, or3 = '0;
    logic [11:0] od3;
    logic [23:0] xc3;

    demux_stream #(.DATA_W(4), .NUM_CH(4), .SEL_W(2), .HOLD_MODE(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .sel_err(sel_err),
        .cnt_clr(cnt_clr), .xfer_cnt(xfer_cnt)
    );

    demux_stream #(.DATA_W(4), .NUM_CH(3), .SEL_W(2), .HOLD_MODE(0)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(v3), .in_ready(r3),
        .in_data(d3), .in_sel(s3), .out_valid(ov3),
        .out_ready(or3), .out_data(od3), .sel_err(se3),
        .cnt_clr(clr3), .xfer_cnt(xc3)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each channel is a queue of words accepted but not yet
    // delivered (a one-word channel can hold at most one).
    logic [3:0] exp_q [4][$];
    logic [3:0] m_last [4];
    int         m_cnt  [4];
    logic [3:0] mon_d;
    logic       exp_rdy;

    // Monitor: compare what the DUT presents, then retire handshaken words.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                exp_q[k].delete();
                m_last[k] = '0;
                m_cnt[k]  = 0;
            end
        end else begin
            check("sel_err", sel_err, 1'b0);
            for (int k = 0; k < 4; k++) begin
                check($sformatf("out_valid[%0d]", k), out_valid[k], exp_q[k].size() != 0);
                mon_d = (exp_q[k].size() != 0) ? exp_q[k][0] : m_last[k];
                check($sformatf("out_data[%0d]", k), out_data[k*4 +: 4], mon_d);
                check($sformatf("xfer_cnt[%0d]", k), xfer_cnt[k*8 +: 8], m_cnt[k]);
                if (exp_q[k].size() != 0 && out_ready[k]) begin
                    m_last[k] = exp_q[k].pop_front();
                    if (m_cnt[k] < 255) m_cnt[k]++;
                end
                if (cnt_clr) m_cnt[k] = 0;
            end
        end
    end

    // Scoreboard push: runs after the monitor has retired this cycle's pops,
    // so a channel is ready exactly when its queue is empty.
    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            exp_rdy = (exp_q[in_sel].size() == 0);
            check("in_ready", in_ready, exp_rdy);
            if (in_valid && exp_rdy) exp_q[in_sel].push_back(in_data);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_cycle();
        in_valid  = ($urandom_range(3) != 0);
        in_sel    = 2'($urandom_range(3));
        in_data   = 4'($urandom_range(15));
        out_ready = 4'($urandom_range(15)) | 4'($urandom_range(15));
        cnt_clr   = ($urandom_range(63) == 0);
        step();
    endtask

    initial begin
        #22 rst_n = 1'b1;
        step();

        // Out-of-range select on the 3-channel instance, then hold-zero behaviour.
        check("dut3 reset valid", ov3, 3'b000);
        check("dut3 reset sel_err", se3, 1'b0);
        s3 = 2'd3; d3 = 4'd9; v3 = 1'b1;
        #1 check("dut3 oob in_ready", r3, 1'b1);
        step();
        v3 = 1'b0;
        check("dut3 sel_err pulse", se3, 1'b1);
        check("dut3 oob valid", ov3, 3'b000);
        check("dut3 oob cnt", xc3, 24'h0);
        step();
        check("dut3 sel_err end", se3, 1'b0);
        s3 = 2'd1; d3 = 4'd6; v3 = 1'b1;
        step();
        v3 = 1'b0;
        check("dut3 load valid", ov3, 3'b010);
        check("dut3 load data", od3[7:4], 4'd6);
        #1 check("dut3 full not ready", r3, 1'b0);
        or3 = 3'b010;
        step();
        or3 = 3'b000;
        check("dut3 pop valid", ov3, 3'b000);
        check("dut3 idle data zero", od3[7:4], 4'd0);
        check("dut3 pop cnt", xc3[15:8], 8'd1);

        // Randomized traffic on the main instance.
        for (int i = 0; i < 1500; i++) rand_cycle();

        // Saturation: stream channel 0 continuously, then clear during a pop.
        in_valid = 1'b1; in_sel = 2'd0; out_ready = 4'hF; cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        for (int i = 0; i < 265; i++) begin
            in_data = 4'($urandom_range(15));
            step();
        end
        check("cnt saturated", xfer_cnt[7:0], 8'd255);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        check("cnt cleared over pop", xfer_cnt[7:0], 8'd0);

        // Fill channels 0 and 3, then reset asynchronously between edges.
        out_ready = 4'h0; in_sel = 2'd0; in_data = 4'd3;
        step();
        in_sel = 2'd3; in_data = 4'd10;
        step();
        in_valid = 1'b0;
        step();
        check("pre-reset ch0/ch3 valid", {out_valid[3], out_valid[0]}, 2'b11);
        #2 rst_n = 1'b0;
        #1;
        check("async rst out_valid", out_valid, 4'h0);
        check("async rst out_data", out_data, 16'h0);
        check("async rst xfer_cnt", xfer_cnt, 32'h0);
        check("async rst sel_err", sel_err, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        in_valid = 1'b1; in_sel = 2'd2; in_data = 4'd11;
        step();
        in_valid = 1'b0;
        check("post-reset valid", out_valid, 4'b0100);
        check("post-reset data", out_data[11:8], 4'd11);

        for (int i = 0; i < 40; i++) rand_cycle();
        in_valid = 1'b0;
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux_stream.md
DEMUX_STREAM -- requirements
Module: demux_stream

Interface
REQ-001 Parameter DATA_W, default 4, payload width in bits.
REQ-002 Parameter NUM_CH, default 4, number of output channels, legal range 2..16.
REQ-003 Parameter SEL_W, default 2, select width; SHALL equal ceil(log2(NUM_CH)).
REQ-004 Parameter HOLD_MODE, default 1; 1 = idle channel keeps last data, 0 = idle channel data forced to zero.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 in_valid  input  1  upstream word present.
REQ-008 in_ready  output  1  block accepts the word this cycle.
REQ-009 in_data  input  DATA_W  payload.
REQ-010 in_sel  input  SEL_W  destination channel index.
REQ-011 out_valid  output  NUM_CH  per-channel word present; bit k = channel k.
REQ-012 out_ready  input  NUM_CH  per-channel downstream accept.
REQ-013 out_data  output  NUM_CH*DATA_W  flattened; channel k at bits [k*DATA_W +: DATA_W].
REQ-014 sel_err  output  1  one-cycle pulse when an out-of-range word is dropped.
REQ-015 cnt_clr  input  1  synchronous clear of all transfer counters.
REQ-016 xfer_cnt  output  NUM_CH*8  flattened per-channel 8-bit delivered-word counters; channel k at [k*8 +: 8].

Function
REQ-017 Each channel SHALL own one output register (data plus valid); the block has no other storage.
REQ-018 Accept (in_valid & in_ready) SHALL load in_data into channel in_sel on the next rising edge and set out_valid[in_sel]; latency is 1 cycle.
REQ-019 For in_sel < NUM_CH, in_ready SHALL be combinational: ~out_valid[in_sel] | out_ready[in_sel].
REQ-020 For in_sel >= NUM_CH, in_ready SHALL be 1; on accept the word is dropped, no channel changes, and sel_err pulses high for exactly the next cycle.
REQ-021 Pop on channel k (out_valid[k] & out_ready[k]) with no accept to k SHALL clear out_valid[k] next cycle.
REQ-022 Simultaneous pop and accept on the same channel SHALL load the new word with out_valid[k] remaining 1 (no bubble).
REQ-023 While out_valid[k] & ~out_ready[k], out_data of channel k SHALL stay stable.
REQ-024 When out_valid[k] = 0: HOLD_MODE=1 keeps the last delivered data; HOLD_MODE=0 drives that channel's data to zero, updated in the same edge that clears valid.
REQ-025 Channels SHALL be independent; a stalled channel SHALL NOT block accepts to other channels.
REQ-026 xfer_cnt[k] SHALL increment by 1 on every pop of channel k and saturate at 255.
REQ-027 cnt_clr SHALL zero all counters next edge and take priority over a same-cycle increment.
REQ-028 in_ready SHALL NOT depend on in_valid; all other outputs SHALL be registered.

Reset
REQ-029 rst_n low SHALL immediately and asynchronously set out_valid=0, out_data=0, xfer_cnt=0, sel_err=0, regardless of clk.
REQ-030 Reset asserted mid-transfer SHALL discard all held words; no pop or counter increment is reported for them.
REQ-031 After rst_n deasserts, the block SHALL accept on the first rising edge where in_valid=1.

Verification (DATA_W=4, NUM_CH=4 unless stated)
REQ-032 All out_ready=1; push sel=0..3 with data 5,5,5,7 back-to-back -> each out_valid[k] high exactly 1 cycle after its accept with matching data; xfer_cnt={1,1,1,1}.
REQ-033 out_ready[2]=0; push sel=2 data 5, then sel=2 data 8 -> second word in_ready=0 held until out_ready[2]=1; channel 2 holds 5 stable; meanwhile a push sel=1 data D is accepted immediately.
REQ-034 Channel 1 full, out_ready[1]=1 and push sel=1 data 13 same cycle -> out_valid[1] stays 1, data becomes 13, xfer_cnt[1] +1.
REQ-035 NUM_CH=3, SEL_W=2: push sel=3 data 9 -> in_ready=1, sel_err pulse 1 cycle, no out_valid change, counters unchanged.
REQ-036 Pop channel 0 260 times, then cnt_clr together with a pop -> xfer_cnt[0] reads 255 before clear, 0 after; HOLD_MODE=0 run shows idle data 0, HOLD_MODE=1 shows last value.
REQ-037 Assert rst_n low between clock edges with channels 0 and 3 valid -> all outputs zero before the next edge; first post-reset push delivered normally.
